// File: rtl/tm_pkg.sv
// rtl/tm_pkg.sv - shared types and constants for the Tsetlin PE column scheduler
package tm_pkg;

  localparam int N_CLAUSE_SLOT = 2;
  localparam int DESC_AW       = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pe_sched_state_e;

  typedef struct packed {
    logic [DESC_AW-1:0] lit_addr;
    logic               inv;
    logic               last;
    logic [1:0]         stage;
    logic               slot;
    logic               eof;
  } pe_desc_t;

endpackage

// File: rtl/pe_col_scheduler_if.sv
// rtl/pe_col_scheduler_if.sv - descriptor stream, literal-read and PE-column control bundle
interface pe_col_scheduler_if #(
  parameter int N_ELEMENT = 4,
  parameter int LIT_AW    = 10
);
  localparam int N_FLAG = N_ELEMENT * tm_pkg::N_CLAUSE_SLOT;

  logic              start;
  logic              desc_valid;
  logic              desc_ready;
  logic [LIT_AW-1:0] desc_lit_addr;
  logic              desc_inv;
  logic              desc_last;
  logic [1:0]        desc_stage;
  logic              desc_slot;
  logic              desc_eof;
  logic              lit_rd_en;
  logic [LIT_AW-1:0] lit_rd_addr;
  logic [1:0]        code_pe_stage;
  logic              pe_ena;
  logic [N_FLAG-1:0] next_clause_flag;
  logic              clause_index;
  logic              inv_en;
  logic              clause_done;
  logic [1:0]        clause_done_stage;
  logic              clause_done_slot;
  logic              busy;
  logic              done;

  modport master (
    output start, desc_valid, desc_lit_addr, desc_inv, desc_last, desc_stage, desc_slot, desc_eof,
    input  desc_ready, lit_rd_en, lit_rd_addr, code_pe_stage, pe_ena, next_clause_flag,
           clause_index, inv_en, clause_done, clause_done_stage, clause_done_slot, busy, done
  );

  modport slave (
    input  start, desc_valid, desc_lit_addr, desc_inv, desc_last, desc_stage, desc_slot, desc_eof,
    output desc_ready, lit_rd_en, lit_rd_addr, code_pe_stage, pe_ena, next_clause_flag,
           clause_index, inv_en, clause_done, clause_done_stage, clause_done_slot, busy, done
  );
endinterface

// File: rtl/pe_sched_pipe.sv
// rtl/pe_sched_pipe.sv - two-stage shift: T+1 PE controls, T+2 clause_done tag
module pe_sched_pipe #(
  parameter int N_FLAG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        in_stage,
  input  logic              in_slot,
  input  logic              in_inv,
  input  logic              in_last,
  input  logic [N_FLAG-1:0] in_flag,
  output logic              pe_ena,
  output logic [1:0]        code_pe_stage,
  output logic              clause_index,
  output logic              inv_en,
  output logic [N_FLAG-1:0] next_clause_flag,
  output logic              clause_done,
  output logic [1:0]        clause_done_stage,
  output logic              clause_done_slot
);

  logic last_q;

  // Fields are zeroed on idle cycles so the column sees clean controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_ena            <= 1'b0;
      code_pe_stage     <= 2'b00;
      clause_index      <= 1'b0;
      inv_en            <= 1'b0;
      next_clause_flag  <= '0;
      last_q            <= 1'b0;
      clause_done       <= 1'b0;
      clause_done_stage <= 2'b00;
      clause_done_slot  <= 1'b0;
    end else begin
      pe_ena            <= in_valid;
      code_pe_stage     <= in_valid ? in_stage : 2'b00;
      clause_index      <= in_valid & in_slot;
      inv_en            <= in_valid & in_inv;
      next_clause_flag  <= in_valid ? in_flag : '0;
      last_q            <= in_valid & in_last;
      clause_done       <= last_q;
      clause_done_stage <= last_q ? code_pe_stage : 2'b00;
      clause_done_slot  <= last_q & clause_index;
    end
  end

endmodule

// File: rtl/pe_col_scheduler.sv
// rtl/pe_col_scheduler.sv - per-column sequencer: frame FSM, fresh-clause tracking, PE pipe
module pe_col_scheduler
  import tm_pkg::*;
#(
  parameter int N_ELEMENT = 4,
  parameter int LIT_AW    = DESC_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_col_scheduler_if.slave  bus
);

  localparam int N_FLAG = N_ELEMENT * N_CLAUSE_SLOT;

  pe_sched_state_e   state, state_nx;
  logic              drain_cnt;
  logic [N_FLAG-1:0] fresh;
  logic [N_FLAG-1:0] flag;
  pe_desc_t          desc;
  logic              hs;
  logic [2:0]        idx;

  assign desc = '{lit_addr: bus.desc_lit_addr, inv: bus.desc_inv, last: bus.desc_last,
                  stage: bus.desc_stage, slot: bus.desc_slot, eof: bus.desc_eof};
  assign hs   = bus.desc_valid & bus.desc_ready;
  assign idx  = {desc.stage, desc.slot};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (hs && desc.eof) state_nx = DRAIN;
      DRAIN:   if (drain_cnt) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.desc_ready = (state == RUN);
    bus.busy       = (state != IDLE);
    bus.done       = (state == DONE);
  end

  // A clause's first descriptor sees fresh=1; a last descriptor re-arms the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fresh <= '1;
    end else if (state == IDLE && bus.start) begin
      fresh <= '1;
    end else if (hs) begin
      fresh[idx] <= desc.last;
    end
  end

  always_comb begin
    flag      = '0;
    flag[idx] = fresh[idx];
  end

  assign bus.lit_rd_en   = hs;
  assign bus.lit_rd_addr = hs ? desc.lit_addr : '0;

  pe_sched_pipe #(.N_FLAG(N_FLAG)) u_pipe (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (hs),
    .in_stage          (desc.stage),
    .in_slot           (desc.slot),
    .in_inv            (desc.inv),
    .in_last           (desc.last),
    .in_flag           (flag),
    .pe_ena            (bus.pe_ena),
    .code_pe_stage     (bus.code_pe_stage),
    .clause_index      (bus.clause_index),
    .inv_en            (bus.inv_en),
    .next_clause_flag  (bus.next_clause_flag),
    .clause_done       (bus.clause_done),
    .clause_done_stage (bus.clause_done_stage),
    .clause_done_slot  (bus.clause_done_slot)
  );

endmodule

// File: tb/tb_pe_col_scheduler.sv
// tb/tb_pe_col_scheduler.sv - randomized self-checking bench for pe_col_scheduler
module tb_pe_col_scheduler;
  import tm_pkg::*;

  localparam int AW   = 10;
  localparam int LOGN = 2048;

  typedef struct packed {
    logic          hs;
    logic          ready;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          pe_ena;
    logic [7:0]    flag;
    logic [1:0]    stg;
    logic          idx;
    logic          inv;
    logic          cd;
    logic [1:0]    cd_stg;
    logic          cd_slot;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  obs_t lg [LOGN];
  bit   clause_open [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_col_scheduler_if #(.N_ELEMENT(4), .LIT_AW(AW)) bus ();
  pe_col_scheduler #(.N_ELEMENT(4), .LIT_AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always @(negedge clk) begin
    if (cyc < LOGN)
      lg[cyc] = '{hs: bus.desc_valid & bus.desc_ready, ready: bus.desc_ready, busy: bus.busy,
                  done: bus.done, rd_en: bus.lit_rd_en, rd_addr: bus.lit_rd_addr,
                  pe_ena: bus.pe_ena, flag: bus.next_clause_flag, stg: bus.code_pe_stage,
                  idx: bus.clause_index, inv: bus.inv_en, cd: bus.clause_done,
                  cd_stg: bus.clause_done_stage, cd_slot: bus.clause_done_slot};
  end

  // Reference: a flag bit is raised only when no clause is open on that {stage,slot}.
  function automatic logic [7:0] model_accept(input logic [1:0] st, input logic sl, input logic last);
    int k;
    logic [7:0] f;
    k = int'(st) * 2 + int'(sl);
    f = 8'h00;
    if (!clause_open[k]) f[k] = 1'b1;
    clause_open[k] = !last;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.start = 1'b0; bus.desc_valid = 1'b0; bus.desc_lit_addr = '0; bus.desc_inv = 1'b0;
    bus.desc_last = 1'b0; bus.desc_stage = 2'b00; bus.desc_slot = 1'b0; bus.desc_eof = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      tick();
      idle_bus();
    end
  endtask

  task automatic frame_start();
    tick();
    idle_bus();
    bus.start = 1'b1;
    for (int k = 0; k < 8; k++) clause_open[k] = 1'b0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic put(input logic [AW-1:0] a, input logic inv, input logic last,
                     input logic [1:0] st, input logic sl, input logic eof, output int c);
    tick();
    bus.start = 1'b0; bus.desc_valid = 1'b1; bus.desc_lit_addr = a; bus.desc_inv = inv;
    bus.desc_last = last; bus.desc_stage = st; bus.desc_slot = sl; bus.desc_eof = eof;
    c = cyc;
  endtask

  task automatic test_reset();
    idle_bus();
    rst_n = 1'b0;
    bus.desc_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.desc_ready, bus.busy, bus.done, bus.pe_ena, bus.clause_done, bus.lit_rd_en} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {bus.desc_ready, bus.busy, bus.done, bus.pe_ena, bus.clause_done, bus.lit_rd_en});
    end
    total++;
    if (bus.next_clause_flag !== 8'h00) begin
      bad++; $display("FAIL reset_flag got=%h want=00", bus.next_clause_flag);
    end
    total++;
    if ({bus.code_pe_stage, bus.clause_index, bus.inv_en, bus.lit_rd_addr,
         bus.clause_done_stage, bus.clause_done_slot} !== '0) begin
      bad++; $display("FAIL reset_fields got nonzero want=0");
    end
    tick();
    rst_n = 1'b1;
    idle_bus();
    gap(2);
  endtask

  task automatic test_single_clause(input string nm);
    int c [3];
    logic [7:0] ef [3];
    frame_start();
    for (int i = 0; i < 3; i++) begin
      put(AW'(10'h040 + i), i[0], i == 2, 2'd1, 1'b0, i == 2, c[i]);
      ef[i] = model_accept(2'd1, 1'b0, i == 2);
    end
    gap(6);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({lg[c[i]].hs, lg[c[i]].rd_en, lg[c[i]].rd_addr} !== {2'b11, AW'(10'h040 + i)}) begin
        bad++; $display("FAIL %s rd[%0d] got=%h want=%h", nm, i, lg[c[i]].rd_addr, 10'h040 + i);
      end
      total++;
      if ({lg[c[i]+1].pe_ena, lg[c[i]+1].flag, lg[c[i]+1].stg, lg[c[i]+1].idx, lg[c[i]+1].inv}
          !== {1'b1, ef[i], 2'd1, 1'b0, i[0]}) begin
        bad++; $display("FAIL %s pe[%0d] got ena=%b flag=%h want flag=%h", nm, i,
                        lg[c[i]+1].pe_ena, lg[c[i]+1].flag, ef[i]);
      end
    end
    total++;
    if ({lg[c[2]+2].cd, lg[c[2]+2].cd_stg, lg[c[2]+2].cd_slot} !== 4'b1_01_0) begin
      bad++; $display("FAIL %s clause_done got=%b want=1010", nm,
                      {lg[c[2]+2].cd, lg[c[2]+2].cd_stg, lg[c[2]+2].cd_slot});
    end
    total++;
    if ({lg[c[0]+2].cd, lg[c[1]+2].cd, lg[c[2]+1].cd} !== 3'b000) begin
      bad++; $display("FAIL %s early_done got=%b want=000", nm,
                      {lg[c[0]+2].cd, lg[c[1]+2].cd, lg[c[2]+1].cd});
    end
    total++;
    if ({lg[c[2]].ready, lg[c[2]+1].ready} !== 2'b10) begin
      bad++; $display("FAIL %s eof_ready got=%b want=10", nm, {lg[c[2]].ready, lg[c[2]+1].ready});
    end
    total++;
    if ({lg[c[2]+2].done, lg[c[2]+3].done, lg[c[2]+4].done} !== 3'b010) begin
      bad++; $display("FAIL %s done_pulse got=%b want=010", nm,
                      {lg[c[2]+2].done, lg[c[2]+3].done, lg[c[2]+4].done});
    end
    total++;
    if ({lg[c[2]+3].busy, lg[c[2]+4].busy} !== 2'b10) begin
      bad++; $display("FAIL %s busy_end got=%b want=10", nm, {lg[c[2]+3].busy, lg[c[2]+4].busy});
    end
  endtask

  task automatic test_interleave();
    int c [8];
    logic [7:0] ef [8];
    logic [1:0] st;
    logic last;
    frame_start();
    for (int i = 0; i < 8; i++) begin
      st   = (i % 2 == 1) ? 2'd3 : 2'd0;
      last = (i == 2) || (i == 5) || (i == 6) || (i == 7);
      put(AW'($urandom), 1'b0, last, st, 1'b1, i == 7, c[i]);
      ef[i] = model_accept(st, 1'b1, last);
    end
    gap(6);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (lg[c[i]+1].flag !== ef[i]) begin
        bad++; $display("FAIL interleave_flag[%0d] got=%h want=%h", i, lg[c[i]+1].flag, ef[i]);
      end
      total++;
      if ({lg[c[i]].ready, lg[c[i]].hs, c[i] - c[0]} !== {2'b11, i}) begin
        bad++; $display("FAIL interleave_ready[%0d] got ready=%b hs=%b offs=%0d want 1 1 %0d",
                        i, lg[c[i]].ready, lg[c[i]].hs, c[i] - c[0], i);
      end
    end
  endtask

  task automatic test_single_literal();
    int c0, c1;
    logic [7:0] f0, f1;
    frame_start();
    put(AW'(10'h155), 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, c0);
    f0 = model_accept(2'd2, 1'b0, 1'b1);
    put(AW'(10'h2AA), 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, c1);
    f1 = model_accept(2'd2, 1'b0, 1'b1);
    gap(6);
    total++;
    if ({lg[c0+1].flag, lg[c1+1].flag} !== {f0, f1}) begin
      bad++; $display("FAIL single_lit_flags got=%h %h want=%h %h", lg[c0+1].flag, lg[c1+1].flag, f0, f1);
    end
    total++;
    if ({lg[c0+2].cd, lg[c1+2].cd, lg[c1+3].cd, c1 - c0} !== {3'b110, 1}) begin
      bad++; $display("FAIL single_lit_done got=%b%b%b gap=%0d want=110 gap=1",
                      lg[c0+2].cd, lg[c1+2].cd, lg[c1+3].cd, c1 - c0);
    end
    total++;
    if ({lg[c0+2].cd_stg, lg[c0+2].cd_slot, lg[c1+2].cd_stg, lg[c1+2].cd_slot} !== 6'b10_0_10_0) begin
      bad++; $display("FAIL single_lit_tags got=%b want=100100",
                      {lg[c0+2].cd_stg, lg[c0+2].cd_slot, lg[c1+2].cd_stg, lg[c1+2].cd_slot});
    end
  endtask

  task automatic test_random();
    int hc [$];
    logic [AW-1:0] ea [$];
    logic [7:0] ef [$];
    logic [1:0] es [$];
    logic esl [$], ei [$], el [$];
    logic [AW-1:0] a;
    logic [1:0] st;
    logic sl, inv, last;
    int c, first, n_pe, n_hs;
    frame_start();
    first = cyc + 1;
    for (int n = 0; n <= 60; n++) begin
      tick();
      idle_bus();
      bus.start = (n == 20);
      if (n == 60 || $urandom_range(0, 1) == 1) begin
        a = AW'($urandom); st = 2'($urandom); sl = 1'($urandom); inv = 1'($urandom);
        last = ($urandom_range(0, 3) == 0);
        bus.desc_valid = 1'b1; bus.desc_lit_addr = a; bus.desc_inv = inv; bus.desc_last = last;
        bus.desc_stage = st; bus.desc_slot = sl; bus.desc_eof = (n == 60);
        hc.push_back(cyc); ea.push_back(a); es.push_back(st); esl.push_back(sl);
        ei.push_back(inv); el.push_back(last); ef.push_back(model_accept(st, sl, last));
      end
    end
    gap(6);
    for (int j = 0; j < hc.size(); j++) begin
      c = hc[j];
      total++;
      if ({lg[c].hs, lg[c].rd_addr} !== {1'b1, ea[j]}) begin
        bad++; $display("FAIL rand_addr[%0d] got hs=%b addr=%h want hs=1 addr=%h", j, lg[c].hs, lg[c].rd_addr, ea[j]);
      end
      total++;
      if ({lg[c+1].pe_ena, lg[c+1].flag, lg[c+1].stg, lg[c+1].idx, lg[c+1].inv}
          !== {1'b1, ef[j], es[j], esl[j], ei[j]}) begin
        bad++; $display("FAIL rand_pe[%0d] got=%h want=%h", j,
                        {lg[c+1].pe_ena, lg[c+1].flag, lg[c+1].stg, lg[c+1].idx, lg[c+1].inv},
                        {1'b1, ef[j], es[j], esl[j], ei[j]});
      end
      total++;
      if ({lg[c+2].cd, lg[c+2].cd_stg, lg[c+2].cd_slot} !== (el[j] ? {1'b1, es[j], esl[j]} : 4'b0)) begin
        bad++; $display("FAIL rand_done[%0d] got=%b want last=%b tag=%b%b", j,
                        {lg[c+2].cd, lg[c+2].cd_stg, lg[c+2].cd_slot}, el[j], es[j], esl[j]);
      end
    end
    n_pe = 0;
    n_hs = 0;
    for (int k = first; k <= hc[hc.size()-1] + 4; k++) begin
      n_pe += int'(lg[k].pe_ena);
      n_hs += int'(lg[k].hs);
    end
    total++;
    if (n_pe != hc.size() || n_hs != hc.size()) begin
      bad++; $display("FAIL rand_count got pe=%0d hs=%0d want=%0d", n_pe, n_hs, hc.size());
    end
  endtask

  task automatic test_reset_midframe();
    int c;
    frame_start();
    put(AW'(10'h3C3), 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, c);
    tick();
    idle_bus();
    rst_n = 1'b0;
    gap(3);
    rst_n = 1'b1;
    gap(2);
    total++;
    if (lg[c].hs !== 1'b1) begin
      bad++; $display("FAIL midreset_hs got=%b want=1", lg[c].hs);
    end
    for (int k = 1; k <= 3; k++) begin
      total++;
      if (lg[c+k] !== '0) begin
        bad++; $display("FAIL midreset_out[%0d] got=%h want=0", k, lg[c+k]);
      end
    end
    total++;
    if ({lg[c+4].pe_ena, lg[c+4].cd, lg[c+5].pe_ena, lg[c+5].cd} !== 4'b0) begin
      bad++; $display("FAIL midreset_late got=%b want=0000",
                      {lg[c+4].pe_ena, lg[c+4].cd, lg[c+5].pe_ena, lg[c+5].cd});
    end
    test_single_clause("after_reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle_bus();
    test_reset();
    test_single_clause("first_frame");
    test_interleave();
    test_single_literal();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_col_scheduler.md
# pe_col_scheduler

Per-column sequencer for one PE column of the Tsetlin clause-evaluation array. It consumes a stream of compressed include-literal descriptors, issues literal-memory reads, and drives the column's control inputs: `code_pe_stage`, `pe_ena`, `next_clause_flag`, `clause_index` and `inv_en`. It tracks clause boundaries per (element, slot) so the partial-AND scratchpads restart correctly. It also tags each clause completion for the class-sum accumulator downstream. One instance sits beside each PE column, between the clause-descriptor buffer and the array.

## Interface
- `N_ELEMENT`, default 4: elements per column. Fixed at 4 because `code_pe_stage` is 2 bits.
- `LIT_AW`, default 10: literal-memory address width.

Ports (name, direction, width, meaning):
- `clk`  in  1  the block's single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a frame. Ignored unless the block is in IDLE.
- `desc_valid`  in  1  a descriptor is presented.
- `desc_ready`  out  1  a descriptor is accepted when `desc_valid` and `desc_ready` are both high.
- `desc_lit_addr`  in  LIT_AW  literal word address.
- `desc_inv`  in  1  use the negated literal.
- `desc_last`  in  1  last literal of this clause.
- `desc_stage`  in  2  element index.
- `desc_slot`  in  1  clause slot (0/1).
- `desc_eof`  in  1  last descriptor of the frame.
- `lit_rd_en`  out  1  literal-memory read strobe. Read data arrives one cycle later and goes straight to the array.
- `lit_rd_addr`  out  LIT_AW  read address.
- `code_pe_stage`  out  2  to the PE column.
- `pe_ena`  out  1  to the PE column.
- `next_clause_flag`  out  2*N_ELEMENT  to the PE column.
- `clause_index`  out  1  to the PE column.
- `inv_en`  out  1  to the PE column.
- `clause_done`  out  1  pulse: the patch result for the tagged clause is valid this cycle.
- `clause_done_stage`  out  2  tag for `clause_done`.
- `clause_done_slot`  out  1  tag for `clause_done`.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle pulse at the end of a frame.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN and DONE.
  - IDLE → RUN on `start`.
  - RUN → DRAIN on the handshake of a descriptor with `desc_eof`=1.
  - DRAIN lasts 2 cycles, then → DONE.
  - DONE lasts 1 cycle (`done`=1), then → IDLE.
- `desc_ready` = (state == RUN) and no eof has yet been accepted. Descriptors presented in IDLE, DRAIN or DONE are not accepted.
- `fresh[8]` holds one bit per {stage, slot}, indexed stage*2+slot.
  - On `start`, all bits are set to 1.
  - A descriptor consumes `fresh[{stage,slot}]`: the bit is cleared, unless `desc_last`=1, in which case it is set back to 1.
  - If a single-literal clause has both `fresh` and `last`, the bit stays 1.
- `next_clause_flag` is one-hot or zero. Bit {stage,slot} is driven to the fresh value sampled at the handshake; all other bits are 0.
- `lit_rd_addr` is taken from `desc_lit_addr`.
- `inv_en`, `clause_index` and `code_pe_stage` are taken from the descriptor fields.
- Back-to-back descriptors to the same {stage,slot} are legal. No stall is inserted, because the PE reads its scratchpad combinationally and writes it on the `pe_ena` edge.
- A clause must contain at least one descriptor.
- A frame that ends with a clause left open (no `last`) produces no `clause_done` for that clause. Its `fresh` bit is reset at the next `start`.

## Timing
- Cycle T (handshake): `lit_rd_en`=1 and `lit_rd_addr` are valid, driven combinationally from the descriptor.
- Cycle T+1: `pe_ena`=1 together with the registered `code_pe_stage`, `clause_index`, `inv_en` and `next_clause_flag`. This aligns with the literal data.
- Cycle T+2: if `desc_last` was 1, `clause_done`=1 with the stage and slot tags. The PE registers its OR result on the T+1→T+2 edge.
- Sustained throughput is 1 descriptor per cycle.
- The eof handshake at T is followed by DRAIN at T+1 and T+2, and by `done` at T+3. The final `clause_done` (T+2) precedes `done`.
- Reset values:
  - All outputs 0, including `desc_ready`, `busy`, `done` and `next_clause_flag`=8'h00.
  - State is IDLE and `fresh` is 8'hFF.
- Reset mid-frame aborts immediately. Any in-flight `pe_ena` and `clause_done` are dropped, and PE scratchpad contents are don't-care.
- `start` during RUN, DRAIN or DONE is ignored.

## Structure
- Shared package `tm_pkg`:
  - the state enum `pe_sched_state_e`;
  - the descriptor struct `pe_desc_t` {lit_addr, inv, last, stage, slot, eof};
  - the constant `N_CLAUSE_SLOT` = 2.
- One sub-module, `pe_sched_pipe`: a 2-stage registered shift of {valid, stage, slot, inv, flag, last} producing the T+1 PE controls and the T+2 `clause_done`.
- The FSM and the `fresh` bookkeeping live in the top module.

## Test plan
- Reset, then `start`. Present 3 descriptors to stage 1, slot 0, with the last one having `last`=1. Required:
  - `next_clause_flag` = 8'h04, 8'h00, 8'h00 on successive `pe_ena` cycles;
  - `clause_done` at handshake+2 with tag (1,0).
- Interleave stage 0 slot 1 and stage 3 slot 1 descriptors every cycle. Required:
  - flags 8'h02 and 8'h80 only on each clause's first descriptor;
  - `desc_ready` stays high throughout (no bubbles).
- A single-literal clause (`last`=1) followed by another literal to the same slot: both get their flag bit set, and there are two `clause_done` pulses 1 cycle apart.
- eof descriptor at cycle T: `desc_ready` drops at T+1, `done` pulses at T+3, then `busy` = 0.
- Toggle `desc_valid` randomly: the `pe_ena` count equals the handshake count, and `lit_rd_addr` matches `desc_lit_addr` in order.
- Assert `rst_n` low while a descriptor is in flight: `pe_ena` and `clause_done` never assert, all outputs read 0, and a new frame after `start` behaves as the first test.
